data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request accept to response valid; legal range 1..15.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1: core presents a load/store request.
REQ-006 SHALL have port req_ready, output, 1: responder accepts request this cycle.
REQ-007 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32: byte address.
REQ-009 SHALL have port req_wdata, input, 32: store data, LSB-aligned.
REQ-010 SHALL have port req_size, input, 2: 00 byte, 01 half, 10 word; 11 illegal.
REQ-011 SHALL have port req_unsigned, input, 1: zero-extend loads when 1, sign-extend when 0.
REQ-012 SHALL have port rsp_valid, output, 1: response available.
REQ-013 SHALL have port rsp_ready, input, 1: core consumes response.
REQ-014 SHALL have port rsp_rdata, output, 32: extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err, output, 1: access faulted; no state changed.

Function
REQ-016 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE; req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request when req_valid && req_ready, capturing all req_* fields that edge.
REQ-018 SHALL assert rsp_valid exactly LATENCY cycles after the accept edge; LATENCY = 1 skips WAIT.
REQ-019 SHALL hold rsp_valid, rsp_rdata, rsp_err stable until rsp_valid && rsp_ready; return to IDLE on that edge.
REQ-020 SHALL NOT accept a new request in the handshake cycle (no back-to-back; min request spacing LATENCY+1).
REQ-021 SHALL index word (addr >> 2) and byte lane addr[1:0]; stores write only the selected lanes.
REQ-022 SHALL perform store writes on the RESP entry edge, so a following load sees the new data.
REQ-023 SHALL flag rsp_err for word index >= DEPTH_WORDS or req_size = 11; store suppressed, rdata = 0.
REQ-024 SHALL extend byte/half loads from bit 7/15 per req_unsigned; word loads unchanged.

Reset
REQ-025 SHALL, on reset low at a clock edge, force IDLE, req_ready = 0 during reset, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, latency counter = 0.
REQ-026 SHALL abandon any in-flight request on reset, including an unissued store (no write).
REQ-027 SHALL NOT clear memory contents on reset.

Configuration
REQ-028 SHALL honour macro DMEM_MISALIGN_TRAP_EN: defined -> half at addr[0]=1 or word at addr[1:0]!=0 gives rsp_err = 1, no write; undefined -> low address bits below access size are ignored (access forced aligned), never an error.

Structure
REQ-029 SHALL take size encodings, FSM state encoding and DEPTH_WORDS default from shared package dmem_pkg.
REQ-030 SHALL place storage in sub-module dmem_array (1 write port with 4 byte enables, 1 read port, combinational read).

Verification
REQ-031 SHALL verify: store word 0x00000004 to addr 0x8, then load word addr 0x8 -> rsp_rdata = 0x00000004, rsp_err = 0, rsp_valid exactly 2 cycles after each accept.
REQ-032 SHALL verify: store byte 0xFF to addr 0x11; load byte signed addr 0x11 -> 0xFFFFFFFF; unsigned -> 0x000000FF; word at 0x10 has only lane 1 changed.
REQ-033 SHALL verify: store word to addr 0x7 (SW x4,4(x3) with x3=3) -> with DMEM_MISALIGN_TRAP_EN rsp_err = 1, word 1 unchanged; without it, word 1 = store data.
REQ-034 SHALL verify: rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready = 0 throughout.
REQ-035 SHALL verify: load addr 4*DEPTH_WORDS -> rsp_err = 1, rsp_rdata = 0.
REQ-036 SHALL verify: reset low one cycle after a store accept -> rsp_valid = 0 next cycle, target word unchanged.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory responder: access size encodings,
// FSM state encoding, default depth, the captured-request record and
// byte-lane helper functions used by the store and load paths.
package dmem_pkg;

    localparam int DMEM_DEPTH_WORDS_DEF = 256;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Decoded request fields that travel from accept to response.
    typedef struct packed {
        logic        we;
        logic        err;
        logic        uns;
        size_e       size;
        logic [1:0]  lane;
        logic [31:0] wdata;
    } dmem_req_t;

    // Byte enables for a store of the given size starting at the given lane.
    function automatic logic [3:0] lane_be(input size_e size, input logic [1:0] lane);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << lane;
            SIZE_HALF: be = 4'b0011 << lane;
            SIZE_WORD: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate LSB-aligned store data onto every lane it could occupy.
    function automatic logic [31:0] lane_wdata(input size_e size, input logic [31:0] wdata);
        logic [31:0] w;
        case (size)
            SIZE_BYTE: w = {4{wdata[7:0]}};
            SIZE_HALF: w = {2{wdata[15:0]}};
            default:   w = wdata;
        endcase
        return w;
    endfunction

    // Pull the addressed lane(s) out of a word and sign/zero extend.
    function automatic logic [31:0] load_extend(input size_e size, input logic uns,
                                                input logic [1:0] lane, input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] r;
        sh = word >> {lane, 3'b000};
        case (size)
            SIZE_BYTE: r = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SIZE_HALF: r = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            SIZE_WORD: r = word;
            default:   r = 32'h0000_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: one byte-enabled write port, one
// combinational read port. Contents are deliberately not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS_DEF,
    parameter int AW          = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Byte-lane write of the selected word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Load/store responder for a core data port. A request is accepted in IDLE,
// the response appears LATENCY cycles after the accept edge and is held
// until the core takes it. Stores commit on the edge that enters RESP.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses fault
// instead of being silently forced aligned.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DMEM_DEPTH_WORDS_DEF,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    state_e        state_q;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic [31:0]   rsp_rdata_q;
    logic [3:0]    cnt_q;
    dmem_req_t     cap_q;
    logic [AW-1:0] widx_q;

    dmem_req_t     dec_s;
    dmem_req_t     act_s;
    logic [AW-1:0] dec_widx_s;
    logic [AW-1:0] act_widx_s;
    logic          accept_s;
    logic          enter_resp_s;
    logic          wr_en_s;
    logic          range_err_s;
    logic          size_err_s;
    logic [31:0]   arr_rdata_s;
    logic [31:0]   rdata_next_s;

    assign accept_s   = (state_q == ST_IDLE) && req_ready_q && req_valid;
    assign dec_widx_s = req_addr[AW+1:2];

    // Decode the incoming request: lane selection, alignment and range faults.
    always_comb begin
        dec_s       = '0;
        size_err_s  = 1'b0;
        range_err_s = 1'b0;
        dec_s.we    = req_we;
        dec_s.uns   = req_unsigned;
        dec_s.size  = size_e'(req_size);
        dec_s.wdata = req_wdata;
        case (size_e'(req_size))
            SIZE_BYTE: begin
                dec_s.lane = req_addr[1:0];
                size_err_s = 1'b0;
            end
            SIZE_HALF: begin
`ifdef DMEM_MISALIGN_TRAP_EN
                dec_s.lane = req_addr[1:0];
                size_err_s = req_addr[0];
`else
                dec_s.lane = {req_addr[1], 1'b0};
                size_err_s = 1'b0;
`endif
            end
            SIZE_WORD: begin
                dec_s.lane = 2'b00;
`ifdef DMEM_MISALIGN_TRAP_EN
                size_err_s = (req_addr[1:0] != 2'b00);
`else
                size_err_s = 1'b0;
`endif
            end
            default: begin
                dec_s.lane = 2'b00;
                size_err_s = 1'b1;
            end
        endcase
        if ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS)) begin
            range_err_s = 1'b1;
        end else begin
            range_err_s = 1'b0;
        end
        dec_s.err = size_err_s | range_err_s;
    end

    // In IDLE the live request drives the datapath (LATENCY=1 commits on the
    // accept edge); otherwise the captured request does.
    always_comb begin
        act_s      = cap_q;
        act_widx_s = widx_q;
        if (state_q == ST_IDLE) begin
            act_s      = dec_s;
            act_widx_s = dec_widx_s;
        end else begin
            act_s      = cap_q;
            act_widx_s = widx_q;
        end
    end

    // Flag the edge on which the FSM enters RESP.
    always_comb begin
        enter_resp_s = 1'b0;
        case (state_q)
            ST_IDLE: enter_resp_s = accept_s && (LATENCY <= 1);
            ST_WAIT: enter_resp_s = (cnt_q == 4'd0);
            default: enter_resp_s = 1'b0;
        endcase
    end

    assign wr_en_s = reset && enter_resp_s && act_s.we && !act_s.err;

    // Response data: extended load value, zero for stores and faults.
    always_comb begin
        rdata_next_s = 32'h0000_0000;
        if (act_s.err || act_s.we) begin
            rdata_next_s = 32'h0000_0000;
        end else begin
            rdata_next_s = load_extend(act_s.size, act_s.uns, act_s.lane, arr_rdata_s);
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_i   (clk),
        .we_i    (wr_en_s),
        .be_i    (lane_be(act_s.size, act_s.lane)),
        .waddr_i (act_widx_s),
        .wdata_i (lane_wdata(act_s.size, act_s.wdata)),
        .raddr_i (act_widx_s),
        .rdata_o (arr_rdata_s)
    );

    // Request/response FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            cnt_q       <= 4'd0;
            cap_q       <= '0;
            widx_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        cap_q       <= dec_s;
                        widx_q      <= dec_widx_s;
                        req_ready_q <= 1'b0;
                        if (enter_resp_s) begin
                            state_q     <= ST_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rdata_next_s;
                            rsp_err_q   <= act_s.err;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (enter_resp_s) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata_next_s;
                        rsp_err_q   <= act_s.err;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'h0000_0000;
                        rsp_err_q   <= 1'b0;
                    end else begin
                        state_q <= ST_RESP;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    rsp_rdata_q <= 32'h0000_0000;
                    rsp_err_q   <= 1'b0;
                    cnt_q       <= 4'd0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed table, stall and
// reset sequences, then random traffic against a byte-level memory model.
module tb_data_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int checks = 0;
    int errors = 0;

    byte unsigned mem_b [4*DEPTH];

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed memory, access computed from size/offset rules.
    function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [1:0] size, input logic uns,
                                  output logic [31:0] rdata, output logic err);
        longint unsigned idx, off, nb, val, a;
        err   = 1'b0;
        rdata = 32'h0;
        idx   = addr / 4;
        off   = addr % 4;
        nb    = 64'd1;
        if (size == 2'd3) begin
            err = 1'b1;
        end else begin
            nb = 64'd1 << size;
`ifdef DMEM_MISALIGN_TRAP_EN
            if ((addr % nb) != 0) err = 1'b1;
`else
            off = off - (off % nb);
`endif
        end
        if (idx >= DEPTH) err = 1'b1;
        if (!err) begin
            a = idx * 4 + off;
            if (we) begin
                for (int i = 0; i < int'(nb); i++) mem_b[a + i] = wdata[8*i +: 8];
            end else begin
                val = 64'd0;
                for (int i = 0; i < int'(nb); i++) val = val | (longint'(mem_b[a + i]) << (8 * i));
                if (!uns && (((val >> (8 * nb - 1)) & 64'd1) == 64'd1))
                    val = val | (64'hFFFF_FFFF_FFFF_FFFF << (8 * nb));
                rdata = val[31:0];
            end
        end
    endfunction

    // One complete transaction with rsp_ready held high.
    task automatic run(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       output logic [31:0] rdata, output logic err, output int lat, output logic ok);
        int w;
        ok  = 1'b1;
        lat = 0;
        rdata = 32'h0;
        err = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        w = 0;
        while (!req_ready && w < 50) begin @(negedge clk); w++; end
        if (!req_ready) begin
            errors++; checks++; ok = 1'b0;
            $display("FAIL req_ready_timeout actual=0 expected=1");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1 req_valid = 1'b0;
        while (lat < 40) begin
            @(negedge clk); lat++;
            if (rsp_valid) break;
        end
        if (!rsp_valid) begin
            errors++; checks++; ok = 1'b0;
            $display("FAIL rsp_valid_timeout actual=0 expected=1");
            return;
        end
        rdata = rsp_rdata;
        err   = rsp_err;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd, erd;
        logic        e, ee, ok;
        int          lat, w;

        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_size = 2'b10; req_unsigned = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_req_ready", {31'h0, req_ready}, 32'h0);
        check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_err",   {31'h0, rsp_err}, 32'h0);
        reset = 1'b1;

        // Fill memory with a known pattern.
        for (int i = 0; i < DEPTH; i++) begin
            model(1'b1, 32'(4 * i), 32'hC0DE_0000 | 32'(i), 2'b10, 1'b0, erd, ee);
            run(1'b1, 32'(4 * i), 32'hC0DE_0000 | 32'(i), 2'b10, 1'b0, rd, e, lat, ok);
            if (ok) check("init_err", {31'h0, e}, 32'h0);
        end

        vecs[0]  = '{"sw_0x8",      1'b1, 32'h8,   32'h0000_0004, 2'b10, 1'b0, 32'h0,         1'b0};
        vecs[1]  = '{"lw_0x8",      1'b0, 32'h8,   32'h0,         2'b10, 1'b0, 32'h0000_0004, 1'b0};
        vecs[2]  = '{"sb_0x11",     1'b1, 32'h11,  32'h0000_00FF, 2'b00, 1'b0, 32'h0,         1'b0};
        vecs[3]  = '{"lb_0x11",     1'b0, 32'h11,  32'h0,         2'b00, 1'b0, 32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{"lbu_0x11",    1'b0, 32'h11,  32'h0,         2'b00, 1'b1, 32'h0000_00FF, 1'b0};
        vecs[5]  = '{"lw_0x10",     1'b0, 32'h10,  32'h0,         2'b10, 1'b0, 32'hC0DE_FF04, 1'b0};
`ifdef DMEM_MISALIGN_TRAP_EN
        vecs[6]  = '{"sw_0x7",      1'b1, 32'h7,   32'h0000_0004, 2'b10, 1'b0, 32'h0,         1'b1};
        vecs[7]  = '{"lw_0x4",      1'b0, 32'h4,   32'h0,         2'b10, 1'b0, 32'hC0DE_0001, 1'b0};
`else
        vecs[6]  = '{"sw_0x7",      1'b1, 32'h7,   32'h0000_0004, 2'b10, 1'b0, 32'h0,         1'b0};
        vecs[7]  = '{"lw_0x4",      1'b0, 32'h4,   32'h0,         2'b10, 1'b0, 32'h0000_0004, 1'b0};
`endif
        vecs[8]  = '{"lw_oob",      1'b0, 32'h400, 32'h0,         2'b10, 1'b0, 32'h0,         1'b1};
        vecs[9]  = '{"size11",      1'b0, 32'h0,   32'h0,         2'b11, 1'b0, 32'h0,         1'b1};
        vecs[10] = '{"lh_0x12",     1'b0, 32'h12,  32'h0,         2'b01, 1'b0, 32'hFFFF_C0DE, 1'b0};
        vecs[11] = '{"lhu_0x12",    1'b0, 32'h12,  32'h0,         2'b01, 1'b1, 32'h0000_C0DE, 1'b0};
        vecs[12] = '{"sw_oob",      1'b1, 32'h400, 32'h1234_5678, 2'b10, 1'b0, 32'h0,         1'b1};
        vecs[13] = '{"lb_0x13",     1'b0, 32'h13,  32'h0,         2'b00, 1'b0, 32'hFFFF_FFC0, 1'b0};

        for (int v = 0; v < 14; v++) begin
            model(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].size, vecs[v].uns, erd, ee);
            run(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].size, vecs[v].uns, rd, e, lat, ok);
            if (ok) begin
                check({vecs[v].name, "_rdata"}, rd, vecs[v].exp_rdata);
                check({vecs[v].name, "_err"}, {31'h0, e}, {31'h0, vecs[v].exp_err});
                check({vecs[v].name, "_lat"}, 32'(lat), 32'(LAT));
            end
        end

        // Response held through a 5-cycle rsp_ready stall.
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8; req_size = 2'b10; req_unsigned = 1'b0;
        w = 0;
        while (!req_ready && w < 50) begin @(negedge clk); w++; end
        @(posedge clk); #1 req_valid = 1'b0;
        w = 0;
        while (!rsp_valid && w < 40) begin @(negedge clk); w++; end
        for (int c = 0; c < 5; c++) begin
            check("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
            check("stall_rsp_rdata", rsp_rdata, 32'h0000_0004);
            check("stall_req_ready", {31'h0, req_ready}, 32'h0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_release", {31'h0, rsp_valid}, 32'h0);

        // Reset one cycle after a store accept: store abandoned.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF; req_size = 2'b10;
        w = 0;
        while (!req_ready && w < 50) begin @(negedge clk); w++; end
        @(posedge clk); #1 req_valid = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_req_ready", {31'h0, req_ready}, 32'h0);
        reset = 1'b1;
        model(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, erd, ee);
        run(1'b0, 32'h20, 32'h0, 2'b10, 1'b0, rd, e, lat, ok);
        if (ok) check("rst_word_kept", rd, 32'hC0DE_0008);

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            logic        rwe, runs;
            logic [31:0] raddr, rwd;
            logic [1:0]  rsz;
            rwe   = 1'($urandom % 2);
            runs  = 1'($urandom % 2);
            raddr = 32'($urandom_range(0, 4 * DEPTH + 15));
            rwd   = $urandom;
            rsz   = 2'($urandom % 4);
            model(rwe, raddr, rwd, rsz, runs, erd, ee);
            run(rwe, raddr, rwd, rsz, runs, rd, e, lat, ok);
            if (ok) begin
                check("rand_rdata", rd, erd);
                check("rand_err", {31'h0, e}, {31'h0, ee});
                check("rand_lat", 32'(lat), 32'(LAT));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
